// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage latches: occupancy state
// encoding, the default bubble instruction and the lane map of the core.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // Instruction word inserted for bubbles unless a stage overrides it.
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    // Lane positions inside the packed stage data bus.
    localparam int LANE_PC = 0;
    localparam int LANE_A  = 1;
    localparam int LANE_B  = 2;
    localparam int LANE_IR = 3;

endpackage

// File: rtl/pipe_stage_latch_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset. Counts one
// per clock while inc_i is high and sticks at the all-ones value.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: step only while requested and not yet at the ceiling.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Count register, cleared only by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_stage_latch.sv
// Pipeline stage register with a 2-entry skid buffer, flush-to-bubble
// and a bubble-cycle performance counter.
//
// Handshake: a word moves across an interface on a rising clock edge
// exactly when valid and ready are both high at that edge. A producer
// holding valid keeps its data stable until the transfer happens;
// in_ready and out_valid come straight from flops so neither depends
// combinationally on the other side of the stage.
module pipe_stage_latch
    import pipe_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               LANES    = 4,
    parameter int               IR_LANE  = LANE_IR,
    parameter logic [WIDTH-1:0] NOP_WORD = WIDTH'(NOP_WORD_DEFAULT)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [1:0]             occupancy,
    output logic [31:0]            bubble_cycles
);

    localparam int DW = LANES * WIDTH;

    // Bus value seen downstream whenever no instruction is present:
    // NOP in the instruction lane, zero everywhere else.
    function automatic logic [DW-1:0] bubble_pattern();
        logic [DW-1:0] p;
        p = '0;
        p[IR_LANE*WIDTH +: WIDTH] = NOP_WORD;
        return p;
    endfunction

    localparam logic [DW-1:0] BUBBLE = bubble_pattern();

    state_e        state_q;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;
    logic          in_ready_q;
    logic          out_valid_q;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    // Occupancy FSM and data registers; in_ready/out_valid are registered
    // alongside the state so they always match the state they describe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= BUBBLE;
            skid_q      <= BUBBLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            // Squash wins over any handshake in the same cycle.
            state_q     <= ST_EMPTY;
            main_q      <= BUBBLE;
            skid_q      <= BUBBLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_q     <= ST_ONE;
                        main_q      <= in_data;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= in_data;
                    end else if (in_xfer) begin
                        // Downstream stalled: park the new word behind main.
                        state_q    <= ST_FULL;
                        skid_q     <= in_data;
                        in_ready_q <= 1'b0;
                    end else if (out_xfer) begin
                        state_q     <= ST_EMPTY;
                        main_q      <= BUBBLE;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        state_q    <= ST_ONE;
                        main_q     <= skid_q;
                        skid_q     <= BUBBLE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    main_q      <= BUBBLE;
                    skid_q      <= BUBBLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    // The state encoding equals the number of held entries.
    assign occupancy = state_q;

    sat_counter #(
        .WIDTH(32)
    ) u_bubble_cnt (
        .clk_i  (clock),
        .rst_i  (reset),
        .inc_i  (~out_valid_q),
        .count_o(bubble_cycles)
    );

endmodule
